// File: rtl/nfc_host_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// nfc_host_pkg
// Shared types and defaults for nfc_host_sequencer.
//   nfc_cmd_t   : controller opcode encoding driven on nfc_cmd / accepted on req_op
//   state_t     : sequencer FSM states
//   DEF_*       : default parameter values for the sequencer
//   is_known_op : true for the four opcodes the controller understands
// -----------------------------------------------------------------------------
package nfc_host_pkg;

  typedef enum logic [2:0] {
    CMD_NOP     = 3'd0,
    CMD_PROGRAM = 3'd1,
    CMD_READ    = 3'd2,
    CMD_RESET   = 3'd3,
    CMD_ERASE   = 3'd4
  } nfc_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_PAGE_WORDS = 16;
  localparam int DEF_TMO_CYCLES = 4096;

  function automatic logic is_known_op(input logic [2:0] op);
    return (op == CMD_PROGRAM) || (op == CMD_READ) ||
           (op == CMD_RESET)   || (op == CMD_ERASE);
  endfunction

endpackage

// File: rtl/nfc_host_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// nfc_host_sequencer
// Host-side initiator for the NAND controller host port. Takes one page request
// (program / read / erase / reset), streams program data into the controller
// page buffer, launches the command, waits for nfc_done, drains read data to
// an output stream and returns a one-cycle completion status.
//
// Ports
//   clk, Reset                 : single rising-edge clock, synchronous active-high reset
//   req_valid/req_ready        : request handshake (ready only in IDLE)
//   req_op, req_addr           : opcode (nfc_cmd_t encoding) and row address
//   wr_valid/wr_ready/wr_data  : program-data stream in (ready only in LOAD)
//   rd_valid/rd_ready/rd_data  : read-data stream out
//   resp_valid/resp_err/resp_tmo : completion pulse with error / watchdog flags
//   nfc_cmd, nfc_start, RWA    : controller command, launch strobe, address
//   buf_sel/buf_we/buf_re/buf_in/buf_out : controller page-buffer access
//   nfc_done, command_error    : controller completion and its error flag
//
// Build option
//   NFC_TIMEOUT_EN : when defined, WAIT is bounded by a TMO_CYCLES watchdog
//                    (measured from nfc_start); otherwise WAIT is unbounded and
//                    resp_tmo is tied low.
// -----------------------------------------------------------------------------
module nfc_host_sequencer
  import nfc_host_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int PAGE_WORDS = DEF_PAGE_WORDS,
  parameter int TMO_CYCLES = DEF_TMO_CYCLES
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              resp_valid,
  output logic              resp_err,
  output logic              resp_tmo,
  output logic [2:0]        nfc_cmd,
  output logic              nfc_start,
  output logic [ADDR_W-1:0] RWA,
  output logic              buf_sel,
  output logic              buf_we,
  output logic              buf_re,
  output logic [DATA_W-1:0] buf_in,
  input  logic [DATA_W-1:0] buf_out,
  input  logic              nfc_done,
  input  logic              command_error
);

  if (PAGE_WORDS < 2 || TMO_CYCLES < 2) begin : g_bad_cfg
    $error("nfc_host_sequencer: PAGE_WORDS and TMO_CYCLES must both be >= 2");
  end

  localparam int                CNT_W      = $clog2(PAGE_WORDS + 1);
  localparam logic [CNT_W-1:0]  LAST_WORD  = CNT_W'(PAGE_WORDS - 1);
  localparam logic [CNT_W:0]    PAGE_LIMIT = (CNT_W + 1)'(PAGE_WORDS);

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    wcnt_q, wcnt_d;
  logic                err_d;

  logic                req_ready_q, req_ready_d;
  logic                wr_ready_q, wr_ready_d;
  logic                buf_sel_q, buf_sel_d;
  logic                nfc_start_q, nfc_start_d;
  logic [2:0]          nfc_cmd_q, nfc_cmd_d;
  logic [ADDR_W-1:0]   rwa_q, rwa_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic                rd_valid_q, rd_valid_d;
  logic                re_q, re_d;
  logic [DATA_W-1:0]   rd_hold_q, rd_hold_d;

  logic                rd_acc;
  logic [CNT_W:0]      issued;

`ifdef NFC_TIMEOUT_EN
  localparam int               TMO_W    = $clog2(TMO_CYCLES);
  // WAIT starts the cycle after nfc_start, so the watchdog fires one count
  // early to land resp_valid exactly TMO_CYCLES after the launch strobe.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 2);
  logic [TMO_W-1:0]            tcnt_q, tcnt_d;
  logic                        tmo_d;
  logic                        resp_tmo_q;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    err_d   = 1'b0;
`ifdef NFC_TIMEOUT_EN
    tmo_d   = 1'b0;
    tcnt_d  = (state_q == ST_WAIT) ? tcnt_q + 1'b1 : '0;
`endif

    // Page-buffer writes follow the wr handshake combinationally so the word
    // and its strobe reach the controller in the cycle they are accepted.
    buf_we = wr_ready_q && wr_valid;
    rd_acc = rd_valid_q && rd_ready;

    // Words already fetched = accepted + the one sitting in the output register.
    // A new fetch is allowed only when that register frees up this cycle.
    issued = {1'b0, wcnt_q} + {{CNT_W{1'b0}}, rd_valid_q};
    buf_re = (state_q == ST_DRAIN) && (!rd_valid_q || rd_ready) && (issued < PAGE_LIMIT);

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          op_d   = req_op;
          addr_d = req_addr;
          wcnt_d = '0;
          case (req_op)
            CMD_PROGRAM:                    state_d = ST_LOAD;
            CMD_READ, CMD_RESET, CMD_ERASE: state_d = ST_START;
            default: begin
              state_d = ST_DONE;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      ST_LOAD: begin
        if (buf_we) begin
          if (wcnt_q == LAST_WORD) begin
            wcnt_d  = '0;
            state_d = ST_START;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (nfc_done) begin
          if (op_q == CMD_READ && !command_error) begin
            state_d = ST_DRAIN;
            wcnt_d  = '0;
          end else begin
            state_d = ST_DONE;
            err_d   = command_error;
          end
        end
`ifdef NFC_TIMEOUT_EN
        else if (tcnt_q == TMO_LAST) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
        end
`endif
      end
      ST_DRAIN: begin
        if (rd_acc) begin
          if (wcnt_q == LAST_WORD) begin
            state_d = ST_DONE;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    req_ready_d  = (state_d == ST_IDLE);
    wr_ready_d   = (state_d == ST_LOAD);
    buf_sel_d    = (state_d == ST_LOAD) || (state_d == ST_DRAIN);
    nfc_start_d  = (state_d == ST_START);
    nfc_cmd_d    = ((state_d == ST_START) || (state_d == ST_WAIT)) ? op_d : CMD_NOP;
    // Address stays on RWA from launch through completion; rejected opcodes
    // never reach the controller, so they leave RWA untouched.
    rwa_d        = (((state_d == ST_START) || (state_d == ST_WAIT) ||
                     (state_d == ST_DRAIN) || (state_d == ST_DONE)) && is_known_op(op_d))
                   ? addr_d : '0;
    resp_valid_d = (state_d == ST_DONE);
    resp_err_d   = err_d;

    rd_valid_d   = buf_re || (rd_valid_q && !rd_ready);
    re_d         = buf_re;
    // buf_out is only guaranteed the cycle after buf_re; keep a copy for stalls.
    rd_hold_d    = re_q ? buf_out : rd_hold_q;
  end

  always_ff @(posedge clk) begin
    op_q      <= op_d;
    addr_q    <= addr_d;
    rd_hold_q <= rd_hold_d;
    if (Reset) begin
      state_q      <= ST_IDLE;
      wcnt_q       <= '0;
      req_ready_q  <= 1'b1;
      wr_ready_q   <= 1'b0;
      buf_sel_q    <= 1'b0;
      nfc_start_q  <= 1'b0;
      nfc_cmd_q    <= CMD_NOP;
      rwa_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      re_q         <= 1'b0;
`ifdef NFC_TIMEOUT_EN
      tcnt_q       <= '0;
      resp_tmo_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      req_ready_q  <= req_ready_d;
      wr_ready_q   <= wr_ready_d;
      buf_sel_q    <= buf_sel_d;
      nfc_start_q  <= nfc_start_d;
      nfc_cmd_q    <= nfc_cmd_d;
      rwa_q        <= rwa_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      rd_valid_q   <= rd_valid_d;
      re_q         <= re_d;
`ifdef NFC_TIMEOUT_EN
      tcnt_q       <= tcnt_d;
      resp_tmo_q   <= tmo_d;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign wr_ready   = wr_ready_q;
  assign buf_sel    = buf_sel_q;
  assign nfc_start  = nfc_start_q;
  assign nfc_cmd    = nfc_cmd_q;
  assign RWA        = rwa_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign rd_valid   = rd_valid_q;
  assign buf_in     = buf_we ? wr_data : '0;
  assign rd_data    = !rd_valid_q ? '0 : (re_q ? buf_out : rd_hold_q);

`ifdef NFC_TIMEOUT_EN
  assign resp_tmo   = resp_tmo_q;
`else
  assign resp_tmo   = 1'b0;
`endif

endmodule
